// File: rtl/spi_chan_sched.sv
// Round-robin scheduler sharing one SPI serializer and its 1-to-4 demux between
// four requesters, with a CS guard gap after each transfer and a hung-transfer timeout.
module spi_chan_sched #(
   parameter int unsigned GUARD_CYCLES = 2,
   parameter int unsigned TIMEOUT      = 255,
   parameter int unsigned CNT_WIDTH    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       xfer_done,
   output logic [3:0] grant,
   output logic [1:0] sel,
   output logic       xfer_start,
   output logic       busy,
   output logic       err,
   output logic [1:0] err_chan
);

   typedef enum logic [1:0] {IDLE, START, WAIT, GUARD} state_t;

   localparam logic [CNT_WIDTH-1:0] GUARD_LOAD   = CNT_WIDTH'(GUARD_CYCLES);
   localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT - 1);

   state_t               state;
   logic [1:0]           last;
   logic [1:0]           winner;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 done_ok;
   logic                 timeout_hit;

   // Scan offsets from farthest to nearest so the closest requester after 'last' wins.
   always_comb begin
      winner = last;
      for (int unsigned i = 4; i >= 1; i--) begin
         if (req[last + 2'(i)]) winner = last + 2'(i);
      end
   end

   // A done coinciding with the start pulse belongs to no transfer and is ignored.
   assign done_ok     = xfer_done && !xfer_start;
   assign timeout_hit = (TIMEOUT != 0) && !done_ok && (cnt == TIMEOUT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         grant      <= '0;
         sel        <= '0;
         xfer_start <= 1'b0;
         busy       <= 1'b0;
         err        <= 1'b0;
         err_chan   <= '0;
         last       <= 2'd3;
         cnt        <= '0;
      end else begin
         xfer_start <= 1'b0;
         err        <= 1'b0;
         case (state)
            IDLE: begin
               if (|req) begin
                  sel   <= winner;
                  grant <= 4'(1) << winner;
                  last  <= winner;
                  state <= START;
                  busy  <= 1'b1;
               end
            end
            START: begin
               xfer_start <= 1'b1;
               cnt        <= '0;
               state      <= WAIT;
            end
            WAIT: begin
               if (done_ok || timeout_hit) begin
                  grant <= '0;
                  if (timeout_hit) begin
                     err      <= 1'b1;
                     err_chan <= sel;
                  end
                  if (GUARD_CYCLES == 0) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= GUARD;
                     cnt   <= GUARD_LOAD;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            GUARD: begin
               if (cnt == CNT_WIDTH'(1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_chan_sched.sv
// Bench for spi_chan_sched: two configurations driven by directed and random stimulus,
// checked every cycle against a transfer-level reference model.
module tb_spi_chan_sched;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, rst_b;
   logic [3:0] req_a, req_b;
   logic       done_a, done_b;
   logic [3:0] grant_a, grant_b;
   logic [1:0] sel_a, sel_b, err_chan_a, err_chan_b;
   logic       xfer_start_a, xfer_start_b, busy_a, busy_b, err_a, err_b;

   spi_chan_sched #(.GUARD_CYCLES(2), .TIMEOUT(8), .CNT_WIDTH(8)) dut_a (
      .clk(clk), .rst(rst_a), .req(req_a), .xfer_done(done_a),
      .grant(grant_a), .sel(sel_a), .xfer_start(xfer_start_a),
      .busy(busy_a), .err(err_a), .err_chan(err_chan_a)
   );

   spi_chan_sched #(.GUARD_CYCLES(0), .TIMEOUT(0), .CNT_WIDTH(4)) dut_b (
      .clk(clk), .rst(rst_b), .req(req_b), .xfer_done(done_b),
      .grant(grant_b), .sel(sel_b), .xfer_start(xfer_start_b),
      .busy(busy_b), .err(err_b), .err_chan(err_chan_b)
   );

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   // Model: owner = channel holding the serializer (-1 none), age = cycles since grant
   // (0 settle, 1 start pulse, >=2 done accepted), gap = guard cycles still to run.
   localparam int GC[2] = '{2, 0};
   localparam int TO[2] = '{8, 0};
   int owner[2], age[2], gap[2], last[2], m_sel[2], m_err_chan[2];
   bit m_start[2], m_err[2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input int k, input logic r, input logic [3:0] rq, input logic dn);
      m_start[k] = 1'b0;
      m_err[k]   = 1'b0;
      if (r) begin
         owner[k] = -1; age[k] = 0; gap[k] = 0; last[k] = 3;
         m_sel[k] = 0; m_err_chan[k] = 0;
      end else if (gap[k] > 0) begin
         gap[k]--;
      end else if (owner[k] >= 0) begin
         if (age[k] == 0) begin
            age[k]     = 1;
            m_start[k] = 1'b1;
         end else begin
            bit fin;
            bit hung;
            fin  = dn && age[k] >= 2;
            hung = !fin && TO[k] != 0 && (age[k] - 1) == TO[k] - 1;
            if (fin || hung) begin
               if (hung) begin
                  m_err[k]      = 1'b1;
                  m_err_chan[k] = owner[k];
               end
               owner[k] = -1;
               gap[k]   = GC[k];
            end else begin
               age[k]++;
            end
         end
      end else if (rq != 4'b0) begin
         for (int i = 1; i <= 4; i++) begin
            int c;
            c = (last[k] + i) % 4;
            if (rq[c]) begin
               owner[k] = c; m_sel[k] = c; last[k] = c; age[k] = 0;
               break;
            end
         end
      end
   endtask

   function automatic logic [31:0] exp_grant(input int k);
      return (owner[k] >= 0) ? (32'd1 << owner[k]) : 32'd0;
   endfunction

   function automatic logic [31:0] exp_busy(input int k);
      return (owner[k] >= 0 || gap[k] > 0) ? 32'd1 : 32'd0;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step(0, rst_a, req_a, done_a);
      model_step(1, rst_b, req_b, done_b);
      #1;
      check("a.grant",    32'(grant_a),      exp_grant(0));
      check("a.sel",      32'(sel_a),        32'(m_sel[0]));
      check("a.start",    32'(xfer_start_a), 32'(m_start[0]));
      check("a.busy",     32'(busy_a),       exp_busy(0));
      check("a.err",      32'(err_a),        32'(m_err[0]));
      check("a.err_chan", 32'(err_chan_a),   32'(m_err_chan[0]));
      check("b.grant",    32'(grant_b),      exp_grant(1));
      check("b.sel",      32'(sel_b),        32'(m_sel[1]));
      check("b.start",    32'(xfer_start_b), 32'(m_start[1]));
      check("b.busy",     32'(busy_b),       exp_busy(1));
      check("b.err",      32'(err_b),        32'(m_err[1]));
      check("b.err_chan", 32'(err_chan_b),   32'(m_err_chan[1]));
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1;
      req_a = '0;   req_b = '0;
      done_a = 1'b0; done_b = 1'b0;
      repeat (2) tick();
      rst_a = 1'b0; rst_b = 1'b0;

      // Single request on A (done 5 cycles after start); B alternates 0/3 with no guard.
      req_a = 4'b0100; req_b = 4'b1001;
      repeat (20) begin
         done_a = owner[0] >= 0 && age[0] == 6;
         done_b = owner[1] >= 0 && age[1] == 3;
         tick();
      end
      req_a = 4'b0000;
      done_a = 1'b0;
      repeat (4) tick();

      // Round robin with every channel requesting, done 3 cycles after start.
      req_a = 4'b1111;
      repeat (45) begin
         done_a = owner[0] >= 0 && age[0] == 4;
         done_b = owner[1] >= 0 && age[1] == 2;
         tick();
      end

      // Hung transfer on channel 1: no done at all.
      req_a = 4'b0010; done_a = 1'b0; done_b = 1'b0;
      repeat (14) tick();
      req_a = 4'b0000;
      repeat (6) tick();

      // Done on the timeout cycle, plus stray dones in idle/guard and on the start pulse.
      req_a = 4'b0010;
      repeat (40) begin
         done_a = owner[0] < 0 || age[0] == 1 || age[0] == 8;
         done_b = owner[1] < 0 || age[1] == 1 || age[1] == 5;
         tick();
      end

      // Reset in the middle of a wait.
      req_a = 4'b1111; done_a = 1'b0;
      for (int n = 0; n < 20 && !(owner[0] >= 0 && age[0] == 3); n++) tick();
      rst_a = 1'b1; rst_b = 1'b1;
      tick();
      rst_a = 1'b0; rst_b = 1'b0;
      repeat (3) tick();

      // Requester drops its request mid-wait; grant must hold until done.
      req_a = 4'b0100;
      repeat (25) begin
         if (owner[0] >= 0 && age[0] == 2) req_a = 4'b0000;
         done_a = owner[0] >= 0 && age[0] == 5;
         tick();
      end

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 7) == 0) req_a = 4'($urandom);
         if ($urandom_range(0, 7) == 0) req_b = 4'($urandom);
         done_a = ($urandom_range(0, 4) == 0);
         done_b = ($urandom_range(0, 3) == 0);
         rst_a  = ($urandom_range(0, 199) == 0);
         rst_b  = ($urandom_range(0, 199) == 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_chan_sched.md
Name: spi_chan_sched

Overview:
- Round-robin scheduler that shares one SPI serializer and its 1-to-4 output demux between four channel requesters.
- Arbitrates requests and drives the demux select, holding it stable for a whole transfer.
- Handshakes with the serializer (start pulse / done pulse), enforces a chip-select guard gap between transfers and aborts hung transfers with an error pulse.

Parameters:
GUARD_CYCLES, 2, idle cycles between end of one transfer and the next grant (CS deassert time); 0 allowed
TIMEOUT, 255, max cycles in WAIT without xfer_done before abort; 0 disables the timeout
CNT_WIDTH, 8, width of the shared guard/timeout counter; GUARD_CYCLES and TIMEOUT must each be < 2^CNT_WIDTH

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
req  input  4  per-channel transfer request (level), bit i = channel i
xfer_done  input  1  one-cycle pulse from serializer: transfer complete
grant  output  4  one-hot grant to the active channel, 0 when none
sel  output  2  demux select (drives the demux ctl input)
xfer_start  output  1  one-cycle pulse to the serializer: begin transfer
busy  output  1  high whenever state != IDLE
err  output  1  one-cycle pulse on timeout abort
err_chan  output  2  channel that timed out; valid from the err pulse until the next err

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, grant=0, sel=0, xfer_start=0, busy=0, err=0, err_chan=0, rr pointer last=3 (channel 0 has highest priority first).
- States: IDLE, START, WAIT, GUARD.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the winner: first set bit scanning last+1, last+2, last+3, last (mod 4).
  - At the edge: sel<=winner, grant<=onehot(winner), last<=winner, state<=START.
- START (exactly 1 cycle):
  - grant and sel are valid; this is the demux settle cycle.
  - At the edge: xfer_start<=1, counter<=0, state<=WAIT.
- WAIT:
  - xfer_start is high only in the first WAIT cycle, then 0.
  - Counter increments each cycle.
  - On xfer_done: grant<=0, then state<=GUARD with counter<=GUARD_CYCLES, or state<=IDLE if GUARD_CYCLES==0.
  - Timeout: if TIMEOUT!=0, xfer_done is low and counter==TIMEOUT-1, abort with err<=1 (1 cycle), err_chan<=sel, grant<=0, then the same GUARD/IDLE transition.
  - Timeout and done in the same cycle: done wins, no err.
- GUARD: counter decrements; state<=IDLE when counter reaches 1. GUARD_CYCLES=N gives exactly N cycles in GUARD.
- Latency: req sampled in IDLE at edge E → grant/sel visible after E, xfer_start high one cycle later.
  - With xfer_done in cycle D: grant drops the cycle after D, and the earliest next grant is GUARD_CYCLES+1 cycles after grant drops.
- sel holds its last value after grant drops; it changes only on a new grant.
- req changes outside IDLE are ignored. A granted channel dropping req mid-transfer does not abort; the transfer runs to done or timeout.
- xfer_done outside WAIT is ignored, including a done in the same cycle as xfer_start.
- Back-to-back requests from one channel while others request: rr pointer guarantees every requester is served within 4 transfers.
- rst asserted in any state: returns to reset values at the next edge, with no xfer_start or err pulse generated; an in-flight transfer is simply abandoned.
- busy is registered from the next state, so it is high in the same cycles as START/WAIT/GUARD.

Test Plan:
- Single request: reset, req=4'b0100, done 5 cycles after start → sel=2 and grant=0100 one cycle after req; xfer_start one pulse the next cycle; grant=0 after done; 2 GUARD cycles; busy low after that.
- Round robin: req=4'b1111 held, done 3 cycles after each start → grant order 0001, 0010, 0100, 1000, 0001; exactly GUARD_CYCLES+1 cycles between grant drop and next grant.
- Timeout: TIMEOUT=8, req=4'b0010, no xfer_done → err pulses 8 cycles after xfer_start, err_chan=1, grant=0, then GUARD and IDLE; no second err.
- Edge collisions:
  - done and timeout in the same cycle → no err, normal completion.
  - xfer_done pulse while in IDLE/GUARD → no state change.
- GUARD_CYCLES=0 with req=4'b1001 constant → WAIT→IDLE directly; grants 0001, 1000, 0001 with one IDLE cycle between transfers.
- Mid-transfer events:
  - rst during WAIT → next cycle grant=0, sel=0, busy=0, state IDLE; first grant afterward goes to channel 0 if requesting.
  - req dropped mid-WAIT → grant held until done.
